aes_cipher_iter: RTL
====================

AES_CIPHER_ITER -- requirements
Module: aes_cipher_iter

Interface
REQ-001 SHALL have parameter Nk, default 4: key length in 32-bit words (4, 6 or 8).
REQ-002 SHALL have parameter Nr, default 10: number of rounds (10, 12 or 14; must match Nk).
REQ-003 SHALL have parameter Nb, default 4: block size in words; only 4 is supported.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port in_valid, input, 1 bit: data_in carries a plaintext block.
REQ-007 SHALL have port in_ready, output, 1 bit: core can accept a block.
REQ-008 SHALL have port data_in, input, 128 bits: plaintext; byte 0 (FIPS-197 in[0]) is bits [127:120]; bytes fill the state column-major.
REQ-009 SHALL have port exp_key, input, 128*(Nr+1) bits: expanded key schedule; round r key is exp_key[128*(Nr+1)-1-128*r -: 128], with word w[0] in the MSBs.
REQ-010 SHALL have port out_valid, output, 1 bit: data_out holds a finished ciphertext.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer accepts data_out.
REQ-012 SHALL have port data_out, output, 128 bits: ciphertext, using the same byte order as data_in.

Function
REQ-013 SHALL implement a 3-state FSM with states IDLE, ROUND and DONE.
REQ-014 SHALL drive in_ready=1 only in IDLE, and out_valid=1 only in DONE.
REQ-015 SHALL treat in_valid&&in_ready at a rising edge as acceptance, at which point:
  - state register <= data_in XOR round key 0
  - round counter <= 1
  - FSM -> ROUND
REQ-016 SHALL, in ROUND, on each edge apply SubBytes, ShiftRows, MixColumns and AddRoundKey(round key r) to the state register, then increment r.
REQ-017 SHALL omit MixColumns when r==Nr.
REQ-018 SHALL, on the edge that completes round Nr, load data_out with the result and move the FSM to DONE.
REQ-019 SHALL assert out_valid exactly Nr clock cycles after the acceptance edge; there are no bubbles.
REQ-020 SHALL, in DONE, hold data_out and out_valid stable until out_valid&&out_ready, and then return to IDLE on that edge.
REQ-021 SHALL never accept a new block on the same edge as output handoff (in_ready is low in DONE); the minimum block-to-block period is therefore Nr+2 cycles.
REQ-022 SHALL ignore in_valid outside IDLE; the caller holds the request.
REQ-023 SHALL sample exp_key combinationally each round; the caller holds exp_key stable from acceptance until out_valid.
REQ-024 SHALL implement MixColumns with xtime over GF(2^8) using reduction 0x1b, with all byte arithmetic 8-bit modulo.
REQ-025 SHALL size the round counter to $clog2(Nr+1) bits and never let it exceed Nr.
REQ-026 SHALL ignore out_ready while not in DONE.

Reset
REQ-027 SHALL, on rst_n low at any time including mid-operation, immediately force:
  - FSM=IDLE
  - round counter=0
  - state register=0
  - data_out=0
  - out_valid=0
  - in_ready=1 (combinational from IDLE)
REQ-028 SHALL discard any in-flight block on reset, and resume accepting on the first rising edge after rst_n deasserts.

Structure
REQ-029 SHALL place the following in shared package aes_pkg, reused by the key-expansion block:
  - Nb constant
  - legal (Nk, Nr) pairs
  - FSM state typedef
  - xtime function
REQ-030 SHALL instantiate sub-module aes_sbox (8-bit combinational S-box) 16 times for SubBytes; ShiftRows and MixColumns remain inline.
REQ-031 SHALL contain no Rcon or key-schedule logic; exp_key comes from the key-expansion stage upstream.

Verification
REQ-032 SHALL pass AES-128 (Nk=4, Nr=10), key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> data_out 3925841d02dc09fbdc118597196a0b32, out_valid 10 cycles after acceptance.
REQ-033 SHALL pass AES-128, key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-034 SHALL pass AES-256 (Nk=8, Nr=14), key 00..1f, pt 00112233445566778899aabbccddeeff -> 8ea2b7ca516745bfeafc49904b496089, out_valid 14 cycles after acceptance.
REQ-035 SHALL pass backpressure: out_ready held low 5 cycles after out_valid -> data_out and out_valid unchanged; in_ready stays 0 until the cycle after handoff.
REQ-036 SHALL pass reset mid-operation: rst_n pulsed low at round 5 -> outputs 0 and in_ready=1 immediately; the next block (REQ-033 vectors) completes correctly.
REQ-037 SHALL pass back-to-back: two blocks with in_valid held high continuously and out_ready=1 -> both ciphertexts correct, second accepted exactly Nr+2 cycles after the first.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES definitions for the cipher core and the key-expansion
// stage. Holds the block size, the legal (Nk, Nr) pairings, the iterative
// core's FSM state type and the GF(2^8) xtime helper.
package aes_pkg;

    // Block size in 32-bit words; AES fixes this at 4.
    localparam int unsigned NB = 4;

    // Legal key-length / round-count pairings: AES-128, AES-192, AES-256.
    localparam int unsigned NK_128 = 4;
    localparam int unsigned NR_128 = 10;
    localparam int unsigned NK_192 = 6;
    localparam int unsigned NR_192 = 12;
    localparam int unsigned NK_256 = 8;
    localparam int unsigned NR_256 = 14;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        DONE
    } aes_state_t;

    // Round count implied by a key length; 0 for an unsupported length.
    function automatic int unsigned aes_nr_for_nk(input int unsigned nk);
        case (nk)
            NK_128:  return NR_128;
            NK_192:  return NR_192;
            NK_256:  return NR_256;
            default: return 0;
        endcase
    endfunction

    function automatic bit aes_params_ok(input int unsigned nk,
                                         input int unsigned nr,
                                         input int unsigned nb);
        return (nb == NB) && (nr != 0) && (aes_nr_for_nk(nk) == nr);
    endfunction

    // Multiply by x in GF(2^8), reduction polynomial x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: 8-bit combinational AES forward S-box (table lookup).
// Ports:
//   value - input byte
//   subst - substituted byte
module aes_sbox (
    input  logic [7:0] value,
    output logic [7:0] subst
);

    // Entry 0x00 sits in the top byte of the table.
    localparam logic [2047:0] SBOX_TAB = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // MSB of entry v is bit 2047-8v = 8*(255-v)+7 = {~v, 3'b111}.
    assign subst = SBOX_TAB[{~value, 3'b111} -: 8];

endmodule

// File: rtl/aes_cipher_iter.sv
// aes_cipher_iter: iterative AES encryption core, one round per clock.
// A block accepted from IDLE has round key 0 added on the accept edge, then
// Nr rounds run in ROUND (MixColumns skipped on the last); the ciphertext is
// held in DONE until the consumer takes it.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_valid, in_ready  - plaintext handshake (in_ready only in IDLE)
//   data_in             - plaintext, byte 0 in bits [127:120], column-major
//   exp_key             - expanded key schedule, round 0 key in the MSBs
//   out_valid, out_ready- ciphertext handshake (out_valid only in DONE)
//   data_out            - ciphertext, same byte order as data_in
module aes_cipher_iter
    import aes_pkg::*;
#(
    parameter int unsigned Nk = 4,
    parameter int unsigned Nr = 10,
    parameter int unsigned Nb = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [127:0]          data_in,
    input  logic [128*(Nr+1)-1:0] exp_key,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [127:0]          data_out
);

    localparam int unsigned KW = 128 * (Nr + 1);
    localparam int unsigned RW = $clog2(Nr + 1);
    localparam logic [RW-1:0] LAST_RND = RW'(Nr);

    if (!aes_params_ok(Nk, Nr, Nb)) begin : g_bad_params
        $error("aes_cipher_iter: unsupported Nk/Nr/Nb combination");
    end

    aes_state_t    fsm_q, fsm_d;
    logic [127:0]  state_q;
    logic [127:0]  data_out_q;
    logic [RW-1:0] rnd_q;

    logic [127:0]  sub, shf, mix, rk, round_out;
    logic          last_rnd;
    logic          accept;

    assign in_ready  = (fsm_q == IDLE);
    assign out_valid = (fsm_q == DONE);
    assign data_out  = data_out_q;
    assign accept    = in_valid && in_ready;
    assign last_rnd  = (rnd_q == LAST_RND);

    // SubBytes
    for (genvar i = 0; i < 16; i++) begin : g_sbox
        aes_sbox u_sbox (
            .value (state_q[127-8*i -: 8]),
            .subst (sub[127-8*i -: 8])
        );
    end

    // ShiftRows: row r of column c takes row r of column (c+r) mod 4.
    always_comb begin
        shf = '0;
        for (int unsigned c = 0; c < NB; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                shf[127-8*(r+4*c) -: 8] = sub[127-8*(r+4*((c+r)%4)) -: 8];
            end
        end
    end

    // MixColumns
    always_comb begin
        logic [7:0] a0, a1, a2, a3;
        mix = '0;
        a0  = '0;
        a1  = '0;
        a2  = '0;
        a3  = '0;
        for (int unsigned c = 0; c < NB; c++) begin
            a0 = shf[127-32*c -: 8];
            a1 = shf[119-32*c -: 8];
            a2 = shf[111-32*c -: 8];
            a3 = shf[103-32*c -: 8];
            mix[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            mix[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            mix[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            mix[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
    end

    // Round-key select for the current round counter.
    always_comb begin
        rk = '0;
        for (int unsigned r = 0; r <= Nr; r++) begin
            if (rnd_q == r[RW-1:0]) begin
                rk = exp_key[KW-1-128*r -: 128];
            end
        end
    end

    assign round_out = (last_rnd ? shf : mix) ^ rk;

    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            IDLE:    if (accept) fsm_d = ROUND;
            ROUND:   if (last_rnd) fsm_d = DONE;
            DONE:    if (out_ready) fsm_d = IDLE;
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q <= IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= '0;
            data_out_q <= '0;
            rnd_q      <= '0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= data_in ^ exp_key[KW-1 -: 128];
                        rnd_q   <= RW'(1);
                    end
                end
                ROUND: begin
                    state_q <= round_out;
                    if (last_rnd) begin
                        data_out_q <= round_out;
                        rnd_q      <= '0;
                    end else begin
                        rnd_q <= rnd_q + RW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
